direction_queue: RTL and testbench
==================================

// Module: direction_queue
// PURPOSE
//  Upstream of snake_body_controller. Turns raw direction pushbuttons into a
//  validated heading. Presses are synchronised, edge-detected and filtered
//  (no repeat, no 180-degree reversal). Accepted turns are buffered in a small
//  FIFO and applied one per snake step, so quick double-turns are not lost.
// PARAMETERS
//  DEPTH      2      turn FIFO entries, legal range 1..4
//  RESET_DIR  2'b00  heading after reset or unfreeze (00=right)
// PORTS
//  clk           in   1  system clock; single clock domain
//  rst           in   1  synchronous reset, active-high
//  direction_pb  in   4  raw buttons {up,down,left,right}, async, active-high
//  move_tick     in   1  1-cycle pulse each time the snake advances one cell
//  game_over     in   1  level; freezes the block while high
//  direction     out  2  current heading: 00 right, 01 left, 10 down, 11 up
//  dir_changed   out  1  1-cycle pulse, cycle after direction is updated
//  queue_count   out  3  number of pending turns, 0..DEPTH
// BEHAVIOUR
//  Reset (rst=1 at a clk edge) sets the following:
//   - direction=RESET_DIR, dir_changed=0, queue_count=0
//   - FIFO pointers cleared, synchroniser/edge flops=0, state=RUN
//   - rst has priority over every other input.
//  Input path:
//   - 2-flop synchroniser per button, then rising-edge detect.
//   - A press reaches the accept stage 3 clk edges after the pin rises.
//   - Held buttons yield exactly one edge.
//   - Several edges in one cycle: keep the highest priority only
//     (up>down>left>right); the rest are dropped.
//  Accept rule for candidate c, using reference r:
//   - r = newest FIFO entry if queue_count>0, else direction.
//   - Reject if c==r.
//   - Reject if c==(r^2'b01), i.e. a reversal.
//   - Reject if queue_count==DEPTH.
//   - Otherwise push c.
//  Pop:
//   - On move_tick with queue_count>0, the head moves to direction at that
//     clk edge.
//   - dir_changed pulses in the following cycle.
//   - move_tick with an empty queue leaves direction unchanged, no pulse.
//  Push and pop in the same cycle:
//   - Both are performed; queue_count is unchanged.
//   - The accept rule uses the pre-pop state.
//   - A push accepted while full-with-pop is still rejected (full is checked
//     before the pop).
//   - No bypass: a turn pushed into an empty queue on a tick cycle is applied
//     at the NEXT tick.
//  Pointers wrap modulo DEPTH; queue_count is never above DEPTH or below 0.
//  FSM: RUN, FROZEN.
//   - RUN->FROZEN when game_over=1: FIFO flushed (count=0), edges ignored,
//     move_tick ignored, direction held, dir_changed=0.
//   - FROZEN->RUN when game_over=0: direction=RESET_DIR, no dir_changed
//     pulse.
//  Reset mid-operation: pending turns discarded; an in-flight synchroniser
//  edge is lost.
//  Outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1. Reset, then hold rst=0. Expect direction=00, queue_count=0. Press up
//     for 5 cycles -> queue_count=1 after 3 edges. Pulse move_tick ->
//     direction=11, and dir_changed=1 for one cycle.
//  2. direction=00: press left -> rejected, queue_count stays 0. Press right
//     -> rejected (repeat).
//  3. direction=00, DEPTH=2: press up, then left, then down -> count=2
//     (down is rejected as full). Two ticks -> direction 11 then 01.
//  4. up and left edges in the same cycle -> only up queued. Next: a push on
//     a move_tick cycle with count=1 -> count stays 1, FIFO order preserved.
//  5. count=2, assert game_over -> count=0, and ticks leave direction
//     unchanged. Deassert -> direction=RESET_DIR, no dir_changed pulse.
//  6. rst asserted while count=2 and a press is in the synchroniser -> next
//     cycle all outputs at reset values; no late push appears.

Source files
------------

// File: rtl/direction_queue_if.sv
// Signal bundle between the pushbutton/game side and direction_queue.
// master drives buttons, move_tick and game_over; slave returns the heading and queue state.
interface direction_queue_if;
  logic [3:0] direction_pb;
  logic       move_tick;
  logic       game_over;
  logic [1:0] direction;
  logic       dir_changed;
  logic [2:0] queue_count;

  modport master (
    output direction_pb, move_tick, game_over,
    input  direction, dir_changed, queue_count
  );

  modport slave (
    input  direction_pb, move_tick, game_over,
    output direction, dir_changed, queue_count
  );
endinterface

// File: rtl/direction_queue.sv
// Turns raw direction buttons into a validated heading. Accepted turns are queued
// and applied one per move_tick, so quick double-turns are not lost.
module direction_queue #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [1:0]  RESET_DIR = 2'b00
) (
  input logic             clk,
  input logic             rst,
  direction_queue_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [2:0] FullCount = 3'(DEPTH);

  typedef enum logic [0:0] {StRun, StFrozen} state_e;

  state_e          state_q;
  logic [3:0]      sync1_q, sync2_q, sync3_q;
  logic [1:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]      count_q;
  logic [1:0]      dir_q;
  logic            dir_changed_q;

  logic [3:0]      pb_edge;
  logic            cand_valid;
  logic [1:0]      cand;
  logic [1:0]      ref_dir;
  logic [PtrW-1:0] last_ptr;
  logic            run_active;
  logic            push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pb_edge    = sync2_q & ~sync3_q;
    cand_valid = |pb_edge;
    // Button bit index equals its heading code, so priority encode straight to the code.
    if (pb_edge[3])      cand = 2'b11;
    else if (pb_edge[2]) cand = 2'b10;
    else if (pb_edge[1]) cand = 2'b01;
    else                 cand = 2'b00;

    last_ptr   = (wr_ptr_q == '0) ? LastPtr : wr_ptr_q - 1'b1;
    ref_dir    = (count_q != 3'd0) ? mem_q[last_ptr] : dir_q;
    run_active = (state_q == StRun) && !bus.game_over;

    // Full is judged before any same-cycle pop.
    push = run_active && cand_valid && (cand != ref_dir) && (cand != (ref_dir ^ 2'b01)) &&
           (count_q != FullCount);
    pop  = run_active && bus.move_tick && (count_q != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      sync3_q       <= '0;
      state_q       <= StRun;
      dir_q         <= RESET_DIR;
      dir_changed_q <= 1'b0;
      count_q       <= 3'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'b00;
    end else begin
      sync1_q       <= bus.direction_pb;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
      dir_changed_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (bus.game_over) begin
            state_q  <= StFrozen;
            count_q  <= 3'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
          end else begin
            if (push) begin
              mem_q[wr_ptr_q] <= cand;
              wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
              dir_q         <= mem_q[rd_ptr_q];
              rd_ptr_q      <= ptr_inc(rd_ptr_q);
              dir_changed_q <= 1'b1;
            end
            if (push && !pop)      count_q <= count_q + 3'd1;
            else if (pop && !push) count_q <= count_q - 3'd1;
          end
        end
        StFrozen: begin
          if (!bus.game_over) begin
            state_q <= StRun;
            dir_q   <= RESET_DIR;
          end
        end
      endcase
    end
  end

  assign bus.direction   = dir_q;
  assign bus.dir_changed = dir_changed_q;
  assign bus.queue_count = count_q;

endmodule

// File: tb/tb_direction_queue.sv
// Directed bench for direction_queue (DEPTH=2, RESET_DIR=00) with hand-computed expectations.
module tb_direction_queue;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  direction_queue_if bus ();

  direction_queue #(.DEPTH(2), .RESET_DIR(2'b00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Hold a button pattern for 'hold' edges, release and let the synchroniser drain.
  task automatic press(input logic [3:0] mask, input int hold);
    bus.direction_pb = mask;
    repeat (hold) cyc();
    bus.direction_pb = 4'b0000;
    repeat (3) cyc();
  endtask

  task automatic tick();
    bus.move_tick = 1'b1;
    cyc();
    bus.move_tick = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.direction_pb = 4'b0000;
    bus.move_tick    = 1'b0;
    bus.game_over    = 1'b0;
    cyc();
    cyc();
    chk("rst_dir", {2'b0, bus.direction}, 4'h0);
    chk("rst_cnt", {1'b0, bus.queue_count}, 4'h0);
    chk("rst_dc", {3'b0, bus.dir_changed}, 4'h0);
    rst = 1'b0;

    // 1: press up, 3-edge latency, one push for a held button, apply on tick
    bus.direction_pb = 4'b1000;
    cyc();
    cyc();
    chk("t1_lat2", {1'b0, bus.queue_count}, 4'h0);
    cyc();
    chk("t1_lat3", {1'b0, bus.queue_count}, 4'h1);
    cyc();
    cyc();
    bus.direction_pb = 4'b0000;
    repeat (3) cyc();
    chk("t1_held", {1'b0, bus.queue_count}, 4'h1);
    tick();
    chk("t1_dir", {2'b0, bus.direction}, 4'h3);
    chk("t1_dc", {3'b0, bus.dir_changed}, 4'h1);
    chk("t1_cnt", {1'b0, bus.queue_count}, 4'h0);
    cyc();
    chk("t1_dc_off", {3'b0, bus.dir_changed}, 4'h0);

    // 2: reversal and repeat rejected
    do_reset();
    press(4'b0010, 3);
    chk("t2_rev", {1'b0, bus.queue_count}, 4'h0);
    press(4'b0001, 3);
    chk("t2_rep", {1'b0, bus.queue_count}, 4'h0);

    // 3: fill to DEPTH, third rejected, FIFO order on ticks, empty tick
    do_reset();
    press(4'b1000, 3);
    press(4'b0010, 3);
    chk("t3_two", {1'b0, bus.queue_count}, 4'h2);
    press(4'b0100, 3);
    chk("t3_full", {1'b0, bus.queue_count}, 4'h2);
    tick();
    chk("t3_pop1", {2'b0, bus.direction}, 4'h3);
    chk("t3_cnt1", {1'b0, bus.queue_count}, 4'h1);
    cyc();
    tick();
    chk("t3_pop2", {2'b0, bus.direction}, 4'h1);
    chk("t3_cnt0", {1'b0, bus.queue_count}, 4'h0);
    cyc();
    tick();
    chk("t3_empty_dir", {2'b0, bus.direction}, 4'h1);
    chk("t3_empty_dc", {3'b0, bus.dir_changed}, 4'h0);

    // 4: simultaneous edges keep up only; push+pop keeps count and order
    do_reset();
    press(4'b1010, 3);
    chk("t4_prio", {1'b0, bus.queue_count}, 4'h1);
    bus.direction_pb = 4'b0010;
    cyc();
    cyc();
    tick();
    chk("t4_pp_cnt", {1'b0, bus.queue_count}, 4'h1);
    chk("t4_pp_dir", {2'b0, bus.direction}, 4'h3);
    bus.direction_pb = 4'b0000;
    repeat (3) cyc();
    tick();
    chk("t4_order", {2'b0, bus.direction}, 4'h1);
    chk("t4_cnt0", {1'b0, bus.queue_count}, 4'h0);
    // No bypass: push into empty queue on a tick cycle waits for the next tick
    bus.direction_pb = 4'b1000;
    cyc();
    cyc();
    tick();
    chk("t4_nobyp_cnt", {1'b0, bus.queue_count}, 4'h1);
    chk("t4_nobyp_dir", {2'b0, bus.direction}, 4'h1);
    chk("t4_nobyp_dc", {3'b0, bus.dir_changed}, 4'h0);
    bus.direction_pb = 4'b0000;
    repeat (3) cyc();
    tick();
    chk("t4_next", {2'b0, bus.direction}, 4'h3);

    // Full with pop: push still rejected
    press(4'b0010, 3);
    press(4'b0100, 3);
    chk("t4_fill", {1'b0, bus.queue_count}, 4'h2);
    bus.direction_pb = 4'b0001;
    cyc();
    cyc();
    tick();
    chk("t4_fullpop_cnt", {1'b0, bus.queue_count}, 4'h1);
    chk("t4_fullpop_dir", {2'b0, bus.direction}, 4'h1);
    bus.direction_pb = 4'b0000;
    repeat (3) cyc();
    press(4'b1000, 3);
    chk("t4_rev_newest", {1'b0, bus.queue_count}, 4'h1);
    press(4'b0001, 3);
    chk("t4_refill", {1'b0, bus.queue_count}, 4'h2);

    // 5: freeze flushes and holds; unfreeze restores RESET_DIR silently
    bus.game_over = 1'b1;
    cyc();
    chk("t5_flush", {1'b0, bus.queue_count}, 4'h0);
    chk("t5_hold", {2'b0, bus.direction}, 4'h1);
    tick();
    tick();
    chk("t5_tick_dir", {2'b0, bus.direction}, 4'h1);
    chk("t5_tick_dc", {3'b0, bus.dir_changed}, 4'h0);
    bus.game_over = 1'b0;
    cyc();
    chk("t5_unfrz_dir", {2'b0, bus.direction}, 4'h0);
    chk("t5_unfrz_dc", {3'b0, bus.dir_changed}, 4'h0);
    cyc();
    chk("t5_unfrz_dc2", {3'b0, bus.dir_changed}, 4'h0);

    // 6: reset with full queue and a press in flight
    press(4'b1000, 3);
    press(4'b0010, 3);
    chk("t6_two", {1'b0, bus.queue_count}, 4'h2);
    bus.direction_pb = 4'b0100;
    cyc();
    rst = 1'b1;
    bus.direction_pb = 4'b0000;
    cyc();
    chk("t6_rst_cnt", {1'b0, bus.queue_count}, 4'h0);
    chk("t6_rst_dir", {2'b0, bus.direction}, 4'h0);
    chk("t6_rst_dc", {3'b0, bus.dir_changed}, 4'h0);
    rst = 1'b0;
    repeat (4) cyc();
    chk("t6_no_late", {1'b0, bus.queue_count}, 4'h0);
    press(4'b1000, 3);
    chk("t6_alive", {1'b0, bus.queue_count}, 4'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
